vigenere_stream_cipher: RTL and testbench

Streaming, parametrised key-based character cipher. It generalises the single-shot fixed-length encryptor into a handshaked byte stream of any length. The key is runtime-loadable up to KEY_MAX characters, and the cipher direction (encrypt or decrypt) is selectable per message. The block sits between a character source and sink; both use valid/ready handshakes, and one message is framed by `last`.

---
 rtl/vigenere_stream_cipher.sv | 149 ++++++++++++++
 tb/tb_vigenere_stream_cipher.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vigenere_stream_cipher.sv
// Streaming key-based character cipher with valid/ready in/out and a runtime-loadable key.
// Define VIGENERE_ALPHA_EN to restrict the cipher to 'A'..'Z' (mod 26) with pass-through otherwise.
module vigenere_stream_cipher #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned KEY_MAX = 16,
  parameter int unsigned KIDX_W  = $clog2(KEY_MAX) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_we,
  input  logic [KIDX_W-1:0] key_addr,
  input  logic [DATA_W-1:0] key_wdata,
  input  logic [KIDX_W-1:0] key_len,
  input  logic              mode,
  input  logic              start,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              err
);

  localparam int unsigned AW    = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e              state_q;
  logic [KIDX_W-1:0]   len_q;
  logic [KIDX_W-1:0]   kidx_q;
  logic                mode_q;
  logic                m_valid_q;
  logic [DATA_W-1:0]   m_data_q;
  logic                m_last_q;
  logic                err_q;

  // Key storage is deliberately unreset so it survives an aborting reset.
  logic [DATA_W-1:0]   key_mem [DEPTH];
  logic [DATA_W-1:0]   key_cur;
  logic [DATA_W-1:0]   cipher;
  logic                advance;
  logic                in_hs;
  logic                out_hs;
  logic                len_ok;
  logic [KIDX_W-1:0]   kidx_nxt;

  assign key_cur  = key_mem[kidx_q[AW-1:0]];
  assign s_ready  = (state_q == StRun) && (!m_valid_q || m_ready);
  assign in_hs    = s_valid && s_ready;
  assign out_hs   = m_valid_q && m_ready;
  assign len_ok   = (key_len != '0) && (key_len <= KIDX_W'(KEY_MAX));
  assign kidx_nxt = (kidx_q == len_q - KIDX_W'(1)) ? '0 : kidx_q + KIDX_W'(1);

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != StIdle);
  assign err     = err_q;

`ifdef VIGENERE_ALPHA_EN
  localparam logic [DATA_W-1:0] ChA = DATA_W'(65);
  localparam logic [DATA_W-1:0] ChZ = DATA_W'(90);
  localparam logic [DATA_W-1:0] Mod = DATA_W'(26);

  logic                is_alpha;
  logic [DATA_W-1:0]   c_off;
  logic [DATA_W-1:0]   k_off;
  logic [DATA_W-1:0]   r;

  always_comb begin
    is_alpha = (s_data >= ChA) && (s_data <= ChZ);
    c_off    = s_data - ChA;
    k_off    = key_cur - ChA;
    r        = '0;
    if (mode_q) begin
      r = (c_off >= k_off) ? (c_off - k_off) : (c_off + Mod - k_off);
    end else begin
      r = c_off + k_off;
      if (r >= Mod) r = r - Mod;
    end
    cipher  = is_alpha ? (r + ChA) : s_data;
    advance = is_alpha;
  end
`else
  always_comb begin
    cipher  = mode_q ? (s_data - key_cur) : (s_data + key_cur);
    advance = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if ((state_q == StIdle) && key_we && (key_addr < KIDX_W'(KEY_MAX))) begin
      key_mem[key_addr[AW-1:0]] <= key_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      kidx_q    <= '0;
      mode_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      // A new accept takes priority over draining, keeping m_valid high.
      if (in_hs) begin
        m_data_q  <= cipher;
        m_last_q  <= s_last;
        m_valid_q <= 1'b1;
      end else if (out_hs) begin
        m_valid_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (len_ok) begin
              len_q   <= key_len;
              mode_q  <= mode;
              kidx_q  <= '0;
              state_q <= StRun;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StRun: begin
          if (in_hs) begin
            if (advance) kidx_q <= kidx_nxt;
            if (s_last) state_q <= StFlush;
          end
        end
        StFlush: begin
          if (out_hs && m_last_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vigenere_stream_cipher.sv
// Directed self-checking bench for vigenere_stream_cipher.
module tb_vigenere_stream_cipher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_we;
  logic [4:0] key_addr;
  logic [7:0] key_wdata;
  logic [4:0] key_len;
  logic       mode;
  logic       start;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;
  logic       err;

  int total = 0;
  int bad   = 0;

  logic [7:0] din  [8];
  logic [7:0] dexp [8];

  vigenere_stream_cipher #(
    .DATA_W (8),
    .KEY_MAX(16),
    .KIDX_W (5)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_we   (key_we),
    .key_addr (key_addr),
    .key_wdata(key_wdata),
    .key_len  (key_len),
    .mode     (mode),
    .start    (start),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_key(input logic [4:0] a, input logic [7:0] d);
    key_we    = 1'b1;
    key_addr  = a;
    key_wdata = d;
    tick();
    key_we    = 1'b0;
  endtask

  task automatic do_start(input logic md, input logic [4:0] len);
    key_len = len;
    mode    = md;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Streams din[0..n-1], checks each output against dexp and the total cycle count.
  task automatic run_msg(input string tag, input int n, input int stall_at, input int stall_len);
    int ii;
    int oi;
    int cyc;
    ii  = 0;
    oi  = 0;
    cyc = 0;
    while (oi < n && cyc < 200) begin
      s_valid = (ii < n);
      s_data  = (ii < n) ? din[ii] : 8'h00;
      s_last  = (ii == n - 1);
      m_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      if (m_valid && !m_ready) begin
        check({tag, "_bp_sready"}, 32'(s_ready), 32'(0));
        check({tag, "_bp_hold"}, 32'(m_data), 32'(dexp[oi]));
      end
      if (m_valid && m_ready) begin
        check($sformatf("%s_data%0d", tag, oi), 32'(m_data), 32'(dexp[oi]));
        check($sformatf("%s_last%0d", tag, oi), 32'(m_last), 32'(oi == n - 1));
        oi++;
      end
      if (s_valid && s_ready) ii++;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check({tag, "_cycles"}, 32'(cyc), 32'(n + 1 + stall_len));
    check({tag, "_idle_busy"}, 32'(busy), 32'(0));
    check({tag, "_idle_mvalid"}, 32'(m_valid), 32'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    key_we    = 1'b0;
    key_addr  = '0;
    key_wdata = '0;
    key_len   = '0;
    mode      = 1'b0;
    start     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    m_ready   = 1'b0;
    #12;
    check("rst_mvalid", 32'(m_valid), 32'(0));
    check("rst_mdata", 32'(m_data), 32'(0));
    check("rst_mlast", 32'(m_last), 32'(0));
    check("rst_sready", 32'(s_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_err", 32'(err), 32'(0));
    rst_n = 1'b1;
    tick();

    write_key(5'd0, 8'h4B);
    write_key(5'd1, 8'h45);
    write_key(5'd2, 8'h59);
    // Out-of-range address must not alias onto entry 0.
    write_key(5'd16, 8'h00);

    do_start(1'b0, 5'd3);
    check("start_busy", 32'(busy), 32'(1));
    check("start_sready", 32'(s_ready), 32'(1));
    check("start_err", 32'(err), 32'(0));

`ifndef VIGENERE_ALPHA_EN
    din[0] = 8'h48; dexp[0] = 8'h93;
    run_msg("single", 1, 0, 0);

    din[0] = 8'h48; din[1] = 8'h45; din[2] = 8'h4C; din[3] = 8'h4C; din[4] = 8'h4F;
    dexp[0] = 8'h93; dexp[1] = 8'h8A; dexp[2] = 8'hA5; dexp[3] = 8'h97; dexp[4] = 8'h94;
    do_start(1'b0, 5'd3);
    run_msg("hello_enc", 5, 0, 0);

    din[0] = 8'h93; din[1] = 8'h8A; din[2] = 8'hA5; din[3] = 8'h97; din[4] = 8'h94;
    dexp[0] = 8'h48; dexp[1] = 8'h45; dexp[2] = 8'h4C; dexp[3] = 8'h4C; dexp[4] = 8'h4F;
    do_start(1'b1, 5'd3);
    run_msg("hello_dec_bp", 5, 2, 4);

    din[0] = 8'hFF; dexp[0] = 8'h4A;
    do_start(1'b0, 5'd1);
    run_msg("carry", 1, 0, 0);

    din[0] = 8'h10; dexp[0] = 8'hC5;
    do_start(1'b1, 5'd1);
    run_msg("borrow", 1, 0, 0);

    do_start(1'b0, 5'd1);
    write_key(5'd0, 8'h11);
    din[0] = 8'hFF; dexp[0] = 8'h4A;
    run_msg("kwe_run", 1, 0, 0);

    do_start(1'b0, 5'd1);
    s_valid = 1'b1;
    s_data  = 8'hFF;
    s_last  = 1'b1;
    m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("abort_pre_mvalid", 32'(m_valid), 32'(1));
    check("abort_pre_mdata", 32'(m_data), 32'(8'h4A));
    rst_n = 1'b0;
    #1;
    check("abort_mvalid", 32'(m_valid), 32'(0));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_sready", 32'(s_ready), 32'(0));
    tick();
    rst_n = 1'b1;
    tick();
    din[0] = 8'hFF; dexp[0] = 8'h4A;
    do_start(1'b0, 5'd1);
    run_msg("key_kept", 1, 0, 0);
`else
    din[0] = 8'h48; din[1] = 8'h45; din[2] = 8'h4C; din[3] = 8'h4C; din[4] = 8'h4F;
    dexp[0] = "R"; dexp[1] = "I"; dexp[2] = "J"; dexp[3] = "V"; dexp[4] = "S";
    run_msg("alpha_enc", 5, 0, 0);

    din[0] = "R"; din[1] = "I"; din[2] = "J"; din[3] = "V"; din[4] = "S";
    dexp[0] = "H"; dexp[1] = "E"; dexp[2] = "L"; dexp[3] = "L"; dexp[4] = "O";
    do_start(1'b1, 5'd3);
    run_msg("alpha_dec_bp", 5, 2, 4);

    // Punctuation holds the key position: Y uses key Y, O uses key K.
    din[0] = "H"; din[1] = "I"; din[2] = ","; din[3] = " "; din[4] = "Y"; din[5] = "O";
    dexp[0] = "R"; dexp[1] = "M"; dexp[2] = ","; dexp[3] = " "; dexp[4] = "W"; dexp[5] = "Y";
    do_start(1'b0, 5'd3);
    run_msg("alpha_punct", 6, 0, 0);
`endif

    do_start(1'b0, 5'd0);
    check("len0_err", 32'(err), 32'(1));
    check("len0_busy", 32'(busy), 32'(0));
    tick();
    check("len0_err_pulse", 32'(err), 32'(0));

    do_start(1'b0, 5'd17);
    check("len17_err", 32'(err), 32'(1));
    check("len17_busy", 32'(busy), 32'(0));
    tick();
    check("len17_err_pulse", 32'(err), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
